fa_cache_lru: RTL
=================

Name: fa_cache_lru

Overview:
Parametrised fully associative cache for the pipelined CPU. It serves the instruction and data ports, has a configurable way count and line size, and keeps true-LRU replacement using per-way age ranks. It adds valid bits, a request/fill handshake toward the memory side, and write-hit word update, all missing from the previous generation. Writes are write-through and no-allocate; the CPU memory path owns the memory write, and this block keeps only its own copy coherent.

Parameters:
WORD_W, 16, data word width in bits
ADDR_W, 16, word address width
LINE_WORDS, 4, words per line; power of two, at least 2
WAYS, 4, number of lines (ways); power of two, at least 2

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
req_valid  in  1  CPU request present
req_ready  out  1  cache can accept a request (high only in IDLE)
req_we  in  1  1 = word write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  WORD_W  write data
resp_valid  out  1  one-cycle pulse: request complete
resp_rdata  out  WORD_W  read data, valid while resp_valid is high
resp_hit  out  1  request hit on lookup, valid while resp_valid is high
fill_req  out  1  line fetch request, held high until fill_valid
fill_addr  out  ADDR_W  line-aligned address (offset bits zero)
fill_valid  in  1  fill data present, one cycle
fill_data  in  LINE_WORDS*WORD_W  word k at [k*WORD_W +: WORD_W]

Behaviour:
- Address split: OFF_W = clog2(LINE_WORDS); offset = addr[OFF_W-1:0]; tag = addr[ADDR_W-1:OFF_W].
- Per-way state: valid, tag, LINE_WORDS data words, age rank of clog2(WAYS) bits.
- Reset (synchronous, reset_n low at posedge):
  - all valid = 0; age[i] = i; FSM to IDLE.
  - resp_valid = 0, resp_hit = 0, resp_rdata = 0, fill_req = 0, fill_addr = 0, req_ready = 1 after reset.
  - Reset mid-fill abandons the fill; a fill_valid arriving afterwards is ignored.
- Hit = valid & tag match; at most one way can match (invariant, assertable).
- FSM states: IDLE, FILL, RESP.
  - IDLE, req_valid & req_ready: latch the request and look up combinationally.
    - Read hit: go to RESP; resp_rdata = matching word; resp_hit = 1.
    - Write hit: store req_wdata into the matching word; go to RESP; resp_hit = 1; resp_rdata = req_wdata.
    - Write miss: no allocate; go to RESP; resp_hit = 0; resp_rdata = 0.
    - Read miss: go to FILL; fill_req = 1; fill_addr = {tag, OFF_W'b0}.
  - FILL: wait for fill_valid, then:
    - pick the victim: lowest-index invalid way, otherwise the way with age == WAYS-1;
    - write the line, valid = 1, tag;
    - resp_rdata = fill word[offset]; resp_hit = 0; fill_req drops the same edge; go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE. req_ready = 0 outside IDLE.
- Latency: hit or write = 2 cycles from accept to resp_valid (accept edge, then RESP). Read miss = fill latency + 2.
- LRU update on every read hit, write hit and fill of way w:
  - every way with age < age[w] increments; age[w] = 0.
  - Ages remain a permutation of 0..WAYS-1 at all times (assertable).
- A write miss does not change ages.
- fill_valid outside FILL is ignored.
- A request held during a non-IDLE state is not accepted until req_ready returns.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined:
  - 32-bit outputs stat_access and stat_hit, zeroed at reset.
  - stat_access increments on every accepted request; stat_hit increments on every accepted request that hits.
  - Counters saturate at all-ones.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package (cache_pkg):
  - OFF_W/tag-width helper functions;
  - FSM state typedef {IDLE, FILL, RESP};
  - default WORD_W/LINE_WORDS/WAYS constants shared with the memory model.
- One sub-module: lru_ages.
  - Holds the age array.
  - Inputs: touch, touch_way.
  - Outputs: victim_way (age == WAYS-1).
- Tag compare and data arrays stay in the top module.

Test Plan:
- Reset, then read 0x0005 -> fill_req with fill_addr 0x0004; fill_data words {0xD3,0xC2,0xB1,0xA0} (word0 = 0xA0) -> resp_rdata 0xB1, resp_hit 0; reread 0x0006 -> 2-cycle response, 0xC2, resp_hit 1.
- Fill lines 0x00, 0x10, 0x20, 0x30 into ways 0-3, read 0x00 again, then miss on 0x40 -> line 0x10 (way 1) is evicted; reread 0x10 -> fill_req.
- Write 0x1234 to cached 0x0002 -> resp_hit 1; read 0x0002 -> 0x1234 with no fill. Write to uncached 0x0100 -> resp_hit 0, no fill, ages unchanged.
- Assert reset_n low while in FILL, then pulse fill_valid -> outputs stay at reset values; next read of that line misses.
- Back-to-back req_valid held high -> req_ready low outside IDLE; every request gets exactly one resp_valid pulse.
- With CACHE_STATS_EN: 3 hits and 2 misses -> stat_access 5, stat_hit 3.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the fully associative cache and the memory model that feeds it.
package cache_pkg;

  localparam int DEF_WORD_W     = 16;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_WAYS       = 4;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_words);
    return addr_w - $clog2(line_words);
  endfunction

endpackage

// File: rtl/fa_cache_lru_lru_ages.sv
// True-LRU age ranks: age 0 is most recent, age WAYS-1 is the replacement victim.
module lru_ages
  import cache_pkg::*;
#(
  parameter int WAYS = DEF_WAYS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    touch,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  output logic [$clog2(WAYS)-1:0] victim_way
);

  localparam int IDX_W = $clog2(WAYS);

  logic [IDX_W-1:0] age [WAYS];
  logic [WAYS-1:0]  seen;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the block order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < WAYS; i++) age[i] <= IDX_W'(i);
    end else if (touch) begin
      for (int i = 0; i < WAYS; i++) begin
        if (IDX_W'(i) == touch_way)    age[i] <= '0;
        else if (age[i] < age[touch_way]) age[i] <= age[i] + 1'b1;
      end
    end
  end

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the loop can leave it holding a value and infer a latch.
  always_comb begin
    victim_way = '0;
    for (int i = 0; i < WAYS; i++)
      if (age[i] == IDX_W'(WAYS - 1)) victim_way = IDX_W'(i);
  end

  always_comb begin
    seen = '0;
    for (int i = 0; i < WAYS; i++) seen[age[i]] = 1'b1;
  end

  ages_are_permutation: assert property (@(posedge clk) disable iff (!reset_n) &seen);

endmodule

// File: rtl/fa_cache_lru.sv
// Fully associative write-through, no-allocate cache with true-LRU replacement.
// Optional hit/access counters are enabled by defining CACHE_STATS_EN.
module fa_cache_lru
  import cache_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int ADDR_W     = 16,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int WAYS       = DEF_WAYS
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [WORD_W-1:0]            req_wdata,
  output logic                         resp_valid,
  output logic [WORD_W-1:0]            resp_rdata,
  output logic                         resp_hit,
  output logic                         fill_req,
  output logic [ADDR_W-1:0]            fill_addr,
  input  logic                         fill_valid,
  input  logic [LINE_WORDS*WORD_W-1:0] fill_data
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                  stat_access,
  output logic [31:0]                  stat_hit
`endif
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int TAG_W = tag_w(ADDR_W, LINE_WORDS);
  localparam int IDX_W = $clog2(WAYS);

  state_t            state;
  logic [WAYS-1:0]   valid;
  logic [TAG_W-1:0]  tag_mem  [WAYS];
  logic [WORD_W-1:0] data_mem [WAYS][LINE_WORDS];
  logic [WORD_W-1:0] fill_words [LINE_WORDS];

  logic [TAG_W-1:0]  req_tag, lat_tag;
  logic [OFF_W-1:0]  req_off, lat_off;
  logic [WAYS-1:0]   hit_vec;
  logic              hit, accept, write_hit, fill_we, touch;
  logic [IDX_W-1:0]  hit_way, inv_way, lru_way, fill_way, touch_way;

  assign req_tag = req_addr[ADDR_W-1:OFF_W];
  assign req_off = req_addr[OFF_W-1:0];

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      hit_vec[i] = valid[i] && (tag_mem[i] == req_tag);
      if (hit_vec[i]) hit_way = IDX_W'(i);
    end
    // Scan downwards so the lowest-index invalid way wins.
    for (int i = WAYS - 1; i >= 0; i--)
      if (!valid[i]) inv_way = IDX_W'(i);
  end

  always_comb begin
    for (int k = 0; k < LINE_WORDS; k++) fill_words[k] = fill_data[k*WORD_W +: WORD_W];
  end

  assign hit       = |hit_vec;
  assign accept    = (state == IDLE) && req_valid;
  assign write_hit = accept && req_we && hit;
  assign fill_we   = (state == FILL) && fill_valid;
  assign fill_way  = (&valid) ? lru_way : inv_way;
  assign touch     = (accept && hit) || fill_we;
  assign touch_way = fill_we ? fill_way : hit_way;

  lru_ages #(.WAYS(WAYS)) u_lru (
    .clk        (clk),
    .reset_n    (reset_n),
    .touch      (touch),
    .touch_way  (touch_way),
    .victim_way (lru_way)
  );

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide
  // whether their contents mean anything, so clearing them would only cost muxes.
  always_ff @(posedge clk) begin
    if (reset_n && fill_we) begin
      tag_mem[fill_way] <= lat_tag;
      for (int k = 0; k < LINE_WORDS; k++) data_mem[fill_way][k] <= fill_words[k];
    end else if (reset_n && write_hit) begin
      data_mem[hit_way][req_off] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      valid      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_rdata <= '0;
      fill_req   <= 1'b0;
      fill_addr  <= '0;
      lat_tag    <= '0;
      lat_off    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          lat_tag   <= req_tag;
          lat_off   <= req_off;
          if (hit || req_we) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_hit   <= hit;
            resp_rdata <= req_we ? (hit ? req_wdata : '0) : data_mem[hit_way][req_off];
          end else begin
            state     <= FILL;
            fill_req  <= 1'b1;
            fill_addr <= {req_tag, {OFF_W{1'b0}}};
          end
        end
        FILL: if (fill_valid) begin
          fill_req        <= 1'b0;
          valid[fill_way] <= 1'b1;
          resp_rdata      <= fill_words[lat_off];
          resp_hit        <= 1'b0;
          resp_valid      <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_access <= '0;
      stat_hit    <= '0;
    end else if (accept) begin
      if (stat_access != '1)    stat_access <= stat_access + 1'b1;
      if (hit && stat_hit != '1) stat_hit    <= stat_hit + 1'b1;
    end
  end
`endif

  single_way_hit: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(hit_vec));

endmodule
